// File: rtl/sdram_burst_model.sv
// SDRAM target model: per-bank open-row tracking, real storage, programmable
// CAS latency / burst length, column-wrapping bursts and command-error pulses.
`timescale 1ns/1ps
module sdram_burst_model #(
  parameter int DQ_W      = 4,
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int BANKS     = 2,
  parameter int CAS_LAT   = 2,
  parameter int BURST_LEN = 8,
  localparam int BA_W     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic             SCLK,
  input  logic             RST,
  input  logic             CS_N,
  input  logic             RAS_N,
  input  logic             CAS_N,
  input  logic             WE_N,
  input  logic [BA_W-1:0]  BA,
  input  logic [ROW_W-1:0] ADDR,
  inout  wire  [DQ_W-1:0]  DQ,
  output logic             DATAEND,
  output logic             CMD_ERR
);

  localparam int NB       = 2 ** BA_W;
  localparam int AW       = BA_W + ROW_W + COL_W;
  localparam int DEPTH    = 1 << AW;
  localparam int BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LAT_INIT = (CAS_LAT > 1) ? CAS_LAT - 2 : 0;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_LAT  = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_WR_DATA = 2'd3;

  localparam logic [2:0] C_ACT   = 3'b011;
  localparam logic [2:0] C_READ  = 3'b101;
  localparam logic [2:0] C_WRITE = 3'b100;
  localparam logic [2:0] C_PRE   = 3'b010;

  logic [DQ_W-1:0]  mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [BA_W-1:0]  bank_q, bank_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [1:0]       lat_q, lat_d;
  logic [DQ_W-1:0]  dq_q, dq_d;
  logic             oe_q, oe_d;
  logic             de_q, de_d;
  logic             err_q;
  logic             open_q [NB];
  logic [ROW_W-1:0] orow_q [NB];

  logic [2:0]       cmd;
  logic             is_act, is_rd, is_wr, is_pre;
  logic             busy, own_bank, act_ok, pre_ok, rw_ok, cmd_err;
  logic [COL_W-1:0] nxt_col;
  logic             we;
  logic [AW-1:0]    waddr;

  assign cmd      = {RAS_N, CAS_N, WE_N};
  assign is_act   = !CS_N && (cmd == C_ACT);
  assign is_rd    = !CS_N && (cmd == C_READ);
  assign is_wr    = !CS_N && (cmd == C_WRITE);
  assign is_pre   = !CS_N && (cmd == C_PRE);
  assign busy     = (state_q != S_IDLE);
  // Only the bank owning the running burst is locked; other banks interleave.
  assign own_bank = busy && (BA == bank_q);
  assign act_ok   = is_act && !open_q[BA] && !own_bank;
  assign pre_ok   = is_pre && !own_bank;
  assign rw_ok    = (is_rd || is_wr) && !busy && open_q[BA];
  assign cmd_err  = (is_act && !act_ok) || (is_pre && !pre_ok) ||
                    ((is_rd || is_wr) && !rw_ok);
  assign nxt_col  = col_q + 1'b1;

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    row_d   = row_q;
    col_d   = col_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    de_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rw_ok) begin
          bank_d = BA;
          row_d  = orow_q[BA];
          col_d  = ADDR[COL_W-1:0];
          beat_d = '0;
          lat_d  = 2'(LAT_INIT);
          if (is_rd) begin
            if (CAS_LAT == 1) begin
              dq_d    = mem[{BA, orow_q[BA], ADDR[COL_W-1:0]}];
              oe_d    = 1'b1;
              de_d    = (BURST_LEN == 1);
              state_d = S_RD_DATA;
            end else begin
              state_d = S_RD_LAT;
            end
          end else if (BURST_LEN > 1) begin
            state_d = S_WR_DATA;
          end
        end
      end
      S_RD_LAT: begin
        if (lat_q == '0) begin
          dq_d    = mem[{bank_q, row_q, col_q}];
          oe_d    = 1'b1;
          de_d    = (BURST_LEN == 1);
          state_d = S_RD_DATA;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RD_DATA: begin
        // The bus holds the beat sampled at this edge; preload the next one.
        if (beat_q == LAST_BEAT) begin
          oe_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          col_d  = nxt_col;
          beat_d = beat_q + 1'b1;
          dq_d   = mem[{bank_q, row_q, nxt_col}];
          de_d   = ((beat_q + 1'b1) == LAST_BEAT);
        end
      end
      default: begin
        col_d  = nxt_col;
        beat_d = beat_q + 1'b1;
        if ((beat_q + 1'b1) == LAST_BEAT) state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = {bank_q, row_q, nxt_col};
    if (!RST) begin
      if (is_wr && rw_ok) begin
        we    = 1'b1;
        waddr = {BA, orow_q[BA], ADDR[COL_W-1:0]};
      end else if (state_q == S_WR_DATA) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (we) mem[waddr] <= DQ;
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < NB; i++) begin
        open_q[i] <= 1'b0;
        orow_q[i] <= '0;
      end
    end else if (act_ok) begin
      open_q[BA] <= 1'b1;
      orow_q[BA] <= ADDR;
    end else if (pre_ok) begin
      open_q[BA] <= 1'b0;
    end
  end

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      beat_q  <= '0;
      lat_q   <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      de_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      row_q   <= row_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      de_q    <= de_d;
      err_q   <= cmd_err;
    end
  end

  assign DQ      = oe_q ? dq_q : 'z;
  assign DATAEND = de_q;
  assign CMD_ERR = err_q;

endmodule

// File: tb/tb_sdram_burst_model.sv
// Bench for sdram_burst_model: two instances (CL2/BL8 and CL1/BL4) checked
// every cycle against a timestamp-based reference, plus hand-computed beats.
`timescale 1ns/1ps
module tb_sdram_burst_model;

  localparam int NSCH = 2048;
  localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100, C_PRE = 3'b010;

  logic SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  logic [1:0] rst = 2'b00;
  logic [1:0] cs_n = 2'b11, ras_n = 2'b11, cas_n = 2'b11, we_n = 2'b11;
  logic [1:0] ba = 2'b00;
  logic [3:0] addr [2];
  logic [1:0] tb_oe = 2'b00;
  logic [3:0] tb_dq [2];
  logic de0, de1, err0, err1;
  tri1 [3:0] dq0, dq1;

  assign dq0 = tb_oe[0] ? tb_dq[0] : 4'bz;
  assign dq1 = tb_oe[1] ? tb_dq[1] : 4'bz;

  sdram_burst_model u_dut0 (
    .SCLK(SCLK), .RST(rst[0]), .CS_N(cs_n[0]), .RAS_N(ras_n[0]), .CAS_N(cas_n[0]),
    .WE_N(we_n[0]), .BA(ba[0]), .ADDR(addr[0]), .DQ(dq0), .DATAEND(de0), .CMD_ERR(err0)
  );

  sdram_burst_model #(.CAS_LAT(1), .BURST_LEN(4)) u_dut1 (
    .SCLK(SCLK), .RST(rst[1]), .CS_N(cs_n[1]), .RAS_N(ras_n[1]), .CAS_N(cas_n[1]),
    .WE_N(we_n[1]), .BA(ba[1]), .ADDR(addr[1]), .DQ(dq1), .DATAEND(de1), .CMD_ERR(err1)
  );

  int cyc = 0;
  always @(posedge SCLK) cyc <= cyc + 1;

  int  tests = 0, fails = 0;
  bit  chk_en = 1'b0;

  // Reference state: what each device must hold, and per-edge expected outputs.
  bit         mopen [2][2];
  logic [3:0] mrow  [2][2];
  int         mbusy [2] = '{-1, -1};
  int         mbank [2];
  logic [3:0] mmem  [2][512];
  logic [3:0] wdat  [2][16];
  bit         xdrv  [2][NSCH];
  logic [3:0] xdq   [2][NSCH];
  bit         xde   [2][NSCH];
  bit         xerr  [2][NSCH];
  logic [3:0] odq   [2][NSCH];
  logic       ode   [2][NSCH];
  logic       oerr  [2][NSCH];

  function automatic int cl(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic int bl(int d); return (d == 0) ? 8 : 4; endfunction
  function automatic int maddr(int b, int r, int c); return b * 256 + r * 16 + (c % 16); endfunction

  task automatic chk(string nm, int d, int k, logic [3:0] act, logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d edge %0d: got %h want %h", nm, d, k, act, exp);
    end
  endtask

  task automatic model(int d, logic [2:0] c, int b, int a, int t0);
    bit busy;
    bit e;
    busy = (t0 <= mbusy[d]);
    e    = 1'b0;
    case (c)
      C_ACT: if (mopen[d][b] || (busy && b == mbank[d])) e = 1'b1;
             else begin mopen[d][b] = 1'b1; mrow[d][b] = 4'(a); end
      C_PRE: if (busy && b == mbank[d]) e = 1'b1; else mopen[d][b] = 1'b0;
      C_RD, C_WR: begin
        if (busy || !mopen[d][b]) e = 1'b1;
        else if (c == C_RD) begin
          for (int i = 0; i < bl(d); i++) begin
            xdrv[d][t0 + cl(d) + i] = 1'b1;
            xdq[d][t0 + cl(d) + i]  = mmem[d][maddr(b, int'(mrow[d][b]), a + i)];
          end
          xde[d][t0 + cl(d) + bl(d) - 1] = 1'b1;
          mbusy[d] = t0 + cl(d) + bl(d) - 1;
          mbank[d] = b;
        end else begin
          for (int i = 0; i < bl(d); i++)
            mmem[d][maddr(b, int'(mrow[d][b]), a + i)] = wdat[d][i];
          mbusy[d] = t0 + bl(d) - 1;
          mbank[d] = b;
        end
      end
      default: ;
    endcase
    if (e) xerr[d][t0 + 1] = 1'b1;
  endtask

  task automatic mreset(int d, int from);
    for (int b = 0; b < 2; b++) mopen[d][b] = 1'b0;
    mbusy[d] = -1;
    for (int k = from; k < NSCH; k++) begin
      xdrv[d][k] = 1'b0; xde[d][k] = 1'b0; xerr[d][k] = 1'b0;
    end
  endtask

  task automatic tick(int n); repeat (n) @(negedge SCLK); endtask

  task automatic nop(int d);
    cs_n[d] = 1'b1; ras_n[d] = 1'b1; cas_n[d] = 1'b1; we_n[d] = 1'b1;
  endtask

  task automatic issue(int d, logic [2:0] c, int b, int a);
    cs_n[d] = 1'b0; {ras_n[d], cas_n[d], we_n[d]} = c;
    ba[d] = 1'(b); addr[d] = 4'(a);
    model(d, c, b, a, cyc + 1);
  endtask

  task automatic single(int d, logic [2:0] c, int b, int a);
    issue(d, c, b, a); tick(1); nop(d);
  endtask

  task automatic write(int d, int b, int a, int first, int step);
    for (int i = 0; i < 16; i++) wdat[d][i] = 4'(first + step * i);
    issue(d, C_WR, b, a);
    tb_oe[d] = 1'b1; tb_dq[d] = wdat[d][0];
    for (int i = 1; i < bl(d); i++) begin
      tick(1); nop(d); tb_dq[d] = wdat[d][i];
    end
    tick(1); nop(d); tb_oe[d] = 1'b0;
  endtask

  // Per-cycle compare, sampled mid-low-phase for the upcoming edge cyc+1.
  initial begin
    forever begin
      @(negedge SCLK);
      #2;
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          int k;
          logic [3:0] adq;
          logic ade, aerr;
          k    = cyc + 1;
          adq  = (d == 0) ? dq0 : dq1;
          ade  = (d == 0) ? de0 : de1;
          aerr = (d == 0) ? err0 : err1;
          odq[d][k] = adq; ode[d][k] = ade; oerr[d][k] = aerr;
          if (!tb_oe[d]) chk("dq", d, k, adq, xdrv[d][k] ? xdq[d][k] : 4'hF);
          chk("dataend", d, k, {3'b0, ade}, {3'b0, xde[d][k]});
          chk("cmd_err", d, k, {3'b0, aerr}, {3'b0, xerr[d][k]});
        end
      end
    end
  end

  initial begin
    int t, t2;
    logic [3:0] wrap_exp [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd7, 4'd8};
    logic [3:0] row3_exp [8] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd7, 4'd8, 4'd9, 4'd10};
    addr[0] = '0; addr[1] = '0; tb_dq[0] = '0; tb_dq[1] = '0;
    #1 rst = 2'b11;
    chk_en = 1'b1;
    tick(3);
    chk("rst_dq", 0, cyc, dq0, 4'hF);
    chk("rst_de", 0, cyc, {3'b0, de0}, 4'h0);
    chk("rst_err", 1, cyc, {3'b0, err1}, 4'h0);
    rst = 2'b00;
    tick(1);

    // Write then read back (CL2, BL8)
    single(0, C_ACT, 0, 3);
    write(0, 0, 2, 3, 1);
    t = cyc + 1;
    single(0, C_RD, 0, 2);
    tick(12);
    for (int i = 0; i < 8; i++) chk("wr_rd_beat", 0, t + 2 + i, odq[0][t + 2 + i], 4'(3 + i));
    chk("wr_rd_de_last", 0, t + 9, {3'b0, ode[0][t + 9]}, 4'h1);
    chk("wr_rd_de_early", 0, t + 8, {3'b0, ode[0][t + 8]}, 4'h0);
    chk("wr_rd_release", 0, t + 10, odq[0][t + 10], 4'hF);

    // Column wrap within the row
    write(0, 0, 14, 1, 1);
    t = cyc + 1;
    single(0, C_RD, 0, 0);
    tick(12);
    for (int i = 0; i < 8; i++) chk("wrap_beat", 0, t + 2 + i, odq[0][t + 2 + i], wrap_exp[i]);

    // Closed-bank read
    t = cyc + 1;
    single(0, C_RD, 1, 0);
    tick(4);
    chk("closed_err", 0, t + 1, {3'b0, oerr[0][t + 1]}, 4'h1);
    chk("closed_err_once", 0, t + 2, {3'b0, oerr[0][t + 2]}, 4'h0);

    // Interleaved ACT accepted, READ and PRE to busy/own bank rejected
    t = cyc + 1;
    single(0, C_RD, 0, 2);
    single(0, C_ACT, 1, 5);
    single(0, C_RD, 1, 0);
    single(0, C_PRE, 0, 0);
    tick(12);
    chk("ilv_act_ok", 0, t + 2, {3'b0, oerr[0][t + 2]}, 4'h0);
    chk("ilv_rd_err", 0, t + 3, {3'b0, oerr[0][t + 3]}, 4'h1);
    chk("ilv_pre_err", 0, t + 4, {3'b0, oerr[0][t + 4]}, 4'h1);
    for (int i = 0; i < 8; i++) chk("ilv_beat", 0, t + 2 + i, odq[0][t + 2 + i], row3_exp[i]);

    // Reset in the middle of a read burst
    t = cyc + 1;
    single(0, C_RD, 0, 2);
    while (cyc < t + 4) @(posedge SCLK);
    #1 rst[0] = 1'b1;
    mreset(0, cyc + 1);
    #1;
    chk("rst_mid_dq", 0, cyc, dq0, 4'hF);
    chk("rst_mid_de", 0, cyc, {3'b0, de0}, 4'h0);
    tick(2);
    rst[0] = 1'b0;
    t2 = cyc + 1;
    single(0, C_RD, 0, 2);
    tick(2);
    chk("post_rst_err", 0, t2 + 1, {3'b0, oerr[0][t2 + 1]}, 4'h1);
    single(0, C_ACT, 0, 3);
    t = cyc + 1;
    single(0, C_RD, 0, 2);
    tick(12);
    for (int i = 0; i < 8; i++) chk("post_rst_beat", 0, t + 2 + i, odq[0][t + 2 + i], row3_exp[i]);

    // Precharge and switch to row 7
    single(0, C_PRE, 0, 0);
    single(0, C_ACT, 0, 7);
    write(0, 0, 2, 9, 0);
    t = cyc + 1;
    single(0, C_RD, 0, 2);
    tick(12);
    for (int i = 0; i < 8; i++) chk("row7_beat", 0, t + 2 + i, odq[0][t + 2 + i], 4'd9);

    // CL1 / BL4 instance: latency, DATAEND, busy boundary, wrap
    single(1, C_ACT, 0, 3);
    write(1, 0, 2, 11, 1);
    t = cyc + 1;
    single(1, C_RD, 0, 2);
    tick(3);
    single(1, C_RD, 0, 2);
    single(1, C_RD, 0, 2);
    tick(8);
    chk("cl1_first", 1, t + 1, odq[1][t + 1], 4'd11);
    chk("cl1_last", 1, t + 4, odq[1][t + 4], 4'd14);
    chk("cl1_de", 1, t + 4, {3'b0, ode[1][t + 4]}, 4'h1);
    chk("cl1_de_early", 1, t + 3, {3'b0, ode[1][t + 3]}, 4'h0);
    chk("cl1_busy_err", 1, t + 5, {3'b0, oerr[1][t + 5]}, 4'h1);
    chk("cl1_gap", 1, t + 5, odq[1][t + 5], 4'hF);
    chk("cl1_reread", 1, t + 6, odq[1][t + 6], 4'd11);
    write(1, 0, 14, 1, 1);
    t = cyc + 1;
    single(1, C_RD, 0, 15);
    tick(6);
    chk("cl1_wrap0", 1, t + 1, odq[1][t + 1], 4'd2);
    chk("cl1_wrap1", 1, t + 2, odq[1][t + 2], 4'd3);
    chk("cl1_wrap3", 1, t + 4, odq[1][t + 4], 4'd11);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
